// File: rtl/frac_dec_seq.sv
// Sequential binary-fraction to decimal converter: one digit per cycle via multiply-by-10.
// Optional round-half-up of the last digit is enabled by defining FRAC_DEC_ROUND_EN.
module frac_dec_seq #(
  parameter int FRAC_W = 24,
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17,
  parameter int LZ_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAC_W-1:0]     in_frac,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [BIN_W-1:0]      out_bin,
  output logic [LZ_W-1:0]       out_lz,
  output logic                  out_carry
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, RND, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [FRAC_W-1:0]   acc;
  logic [FRAC_W+3:0]   prod;
  logic [3:0]          digit;
  logic                last_digit;
  logic [4*DIGITS-1:0] bcd;
  logic [BIN_W-1:0]    bin;
  logic [LZ_W-1:0]     lz;

`ifdef FRAC_DEC_ROUND_EN
  logic                carry;
  logic [4*DIGITS-1:0] bcd_rnd;
  logic                rnd_carry;

  // Decimal increment with carry ripple from the least significant digit
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [LZ_W-1:0] count_lz(input logic [4*DIGITS-1:0] v);
    logic [LZ_W-1:0] n;
    logic            seen;
    n    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!seen && v[4*i +: 4] == 4'd0) n = n + LZ_W'(1);
      else                              seen = 1'b1;
    end
    return n;
  endfunction

  assign bcd_rnd   = bcd_inc(bcd);
  // Only an all-nines vector wraps to zero on increment
  assign rnd_carry = (bcd_rnd == '0);
  assign out_carry = carry;
`else
  assign out_carry = 1'b0;
`endif

  // Shift-add times ten keeps the top nibble as the next decimal digit
  assign prod       = ({4'b0, acc} << 3) + ({4'b0, acc} << 1);
  assign digit      = prod[FRAC_W+3:FRAC_W];
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_bcd   = bcd;
  assign out_bin   = bin;
  assign out_lz    = lz;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CONV;
      CONV: begin
        if (last_digit) begin
`ifdef FRAC_DEC_ROUND_EN
          state_nxt = RND;
`else
          state_nxt = DONE;
`endif
        end
      end
      RND:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Working fraction: loaded on accept, replaced by the residual each digit
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) acc <= in_frac;
    else if (state == CONV)        acc <= prod[FRAC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      bcd <= '0;
      bin <= '0;
      lz  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            bcd <= '0;
            bin <= '0;
            lz  <= '0;
          end
        end
        CONV: begin
          cnt <= last_digit ? '0 : cnt + CNT_W'(1);
          bcd <= {bcd[4*DIGITS-5:0], digit};
          bin <= bin * BIN_W'(10) + BIN_W'(digit);
          // bin is still zero exactly while every earlier digit was zero
          if (bin == '0 && digit == 4'd0) lz <= lz + LZ_W'(1);
        end
`ifdef FRAC_DEC_ROUND_EN
        RND: begin
          if (acc[FRAC_W-1]) begin
            bcd <= bcd_rnd;
            bin <= bin + BIN_W'(1);
            lz  <= rnd_carry ? '0 : count_lz(bcd_rnd);
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef FRAC_DEC_ROUND_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          carry <= 1'b0;
    else if (state == IDLE && in_valid)  carry <= 1'b0;
    else if (state == RND)               carry <= acc[FRAC_W-1] & rnd_carry;
  end
`endif

endmodule

// File: tb/tb_frac_dec_seq.sv
// Bench for frac_dec_seq: directed and random fractions against an arithmetic reference.
module tb_frac_dec_seq;
  localparam int FRAC_W = 24;
  localparam int DIGITS = 5;
  localparam int BIN_W  = 17;
  localparam int LZ_W   = 3;
`ifdef FRAC_DEC_ROUND_EN
  localparam bit RND_ON = 1'b1;
  localparam int LAT    = DIGITS + 1;
`else
  localparam bit RND_ON = 1'b0;
  localparam int LAT    = DIGITS;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [FRAC_W-1:0]   in_frac;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic [BIN_W-1:0]    out_bin;
  logic [LZ_W-1:0]     out_lz;
  logic                out_carry;

  int passed = 0;
  int total  = 0;

  frac_dec_seq #(.FRAC_W(FRAC_W), .DIGITS(DIGITS), .BIN_W(BIN_W), .LZ_W(LZ_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_bin(out_bin),
    .out_lz(out_lz), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  // Reference: value = floor(frac * 10^DIGITS / 2^FRAC_W), optionally rounded half-up
  task automatic model(input logic [23:0] f, output logic [19:0] bcd, output logic [16:0] bin,
                       output logic [2:0] lz, output logic c);
    longint prod, v, rem, t;
    int     n;
    bit     seen;
    prod = longint'(f) * 100000;
    v    = prod >>> 24;
    rem  = prod & 64'hFFFFFF;
    if (RND_ON && rem >= 64'h800000) v = v + 1;
    c    = (v == 100000);
    bin  = v[16:0];
    bcd  = '0;
    lz   = '0;
    if (!c) begin
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      n = 0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (!seen && bcd[4*i +: 4] == 4'd0) n++;
        else seen = 1'b1;
      end
      lz = 3'(n);
    end
  endtask

  // Called at a negedge; returns at the first negedge with out_valid high (or bound expiry)
  task automatic run_conv(input logic [23:0] f, output logic [19:0] bcd, output logic [16:0] bin,
                          output logic [2:0] lz, output logic c, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_frac  = f;
    @(negedge clk);
    in_valid = 1'b0;
    in_frac  = 24'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    bcd = out_bcd;
    bin = out_bin;
    lz  = out_lz;
    c   = out_carry;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_frac = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_bcd, out_bin, out_lz, out_carry} !== '0)
      $display("FAIL reset_outputs got v=%b bcd=%h bin=%0d lz=%0d c=%b want all 0",
               out_valid, out_bcd, out_bin, out_lz, out_carry);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic check_conv(input string name, input logic [23:0] f);
    logic [19:0] bcd, ebcd;
    logic [16:0] bin, ebin;
    logic [2:0]  lz, elz;
    logic        c, ec;
    int          lat;
    model(f, ebcd, ebin, elz, ec);
    run_conv(f, bcd, bin, lz, c, lat);
    total++;
    if (lat !== LAT) $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
    else passed++;
    total++;
    if (bcd !== ebcd || bin !== ebin || lz !== elz || c !== ec)
      $display("FAIL %s frac=%h got bcd=%h bin=%0d lz=%0d c=%b want bcd=%h bin=%0d lz=%0d c=%b",
               name, f, bcd, bin, lz, c, ebcd, ebin, elz, ec);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL %s in_ready_done got %b want 0", name, in_ready);
    else passed++;
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s handshake got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_directed();
    logic [23:0] vec [5];
    vec[0] = 24'h800000; vec[1] = 24'h004000; vec[2] = 24'h000000;
    vec[3] = 24'hFFFFFF; vec[4] = 24'h400000;
    for (int i = 0; i < 5; i++) check_conv($sformatf("directed%0d", i), vec[i]);
  endtask

  task automatic test_literal();
    logic [19:0] bcd;
    logic [16:0] bin;
    logic [2:0]  lz;
    logic        c;
    int          lat;
    run_conv(24'h004000, bcd, bin, lz, c, lat);
    total++;
    if (RND_ON ? (bcd !== 20'h00098 || bin !== 17'd98) : (bcd !== 20'h00097 || bin !== 17'd97 || lz !== 3'd3))
      $display("FAIL literal_2m10 got bcd=%h bin=%0d lz=%0d", bcd, bin, lz);
    else passed++;
    release_out();
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) check_conv("random", 24'($urandom));
  endtask

  task automatic test_backpressure();
    logic [19:0] bcd, ebcd;
    logic [16:0] bin, ebin;
    logic [2:0]  lz, elz;
    logic        c, ec;
    int          lat;
    model(24'h123456, ebcd, ebin, elz, ec);
    run_conv(24'h123456, bcd, bin, lz, c, lat);
    in_valid = 1'b1;
    in_frac  = 24'h800000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== ebcd || out_bin !== ebin ||
          out_lz !== elz || out_carry !== ec)
        $display("FAIL backpressure_hold%0d got v=%b rdy=%b bcd=%h bin=%0d want v=1 rdy=0 bcd=%h bin=%0d",
                 i, out_valid, in_ready, out_bcd, out_bin, ebcd, ebin);
      else passed++;
    end
    in_valid = 1'b0;
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_no_take got v=%b rdy=%b want 0/1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) check_conv("back_to_back", 24'($urandom));
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_frac  = 24'hABCDEF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_bcd, out_bin, out_lz, out_carry} !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_mid got v=%b bcd=%h bin=%0d lz=%0d c=%b rdy=%b want zeros rdy=1",
               out_valid, out_bcd, out_bin, out_lz, out_carry, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIGITS + 2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_mid_no_result got v=%b want 0", out_valid);
    else passed++;
    check_conv("after_reset", 24'h400000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_literal();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
